// File: rtl/fifo_pkg.sv
// Shared types and helpers for the skewed FIFO bank.
//   skew_state_t : controller state (IDLE accepts load/push/start, DRAIN emits)
//   cnt_w()      : width of the drain counter, which must hold 0..depth+lanes-2
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } skew_state_t;

  function automatic int cnt_w(input int depth, input int lanes);
    return ((depth + lanes - 1) > 1) ? $clog2(depth + lanes - 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_lane.sv
// One delay lane of the skewed FIFO bank: DEPTH x BITS shift register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears every entry)
//   load      : parallel overwrite of all entries from load_vec
//   load_vec  : load_vec[k] -> entry k
//   shift     : move every entry one step toward 0, shift_in enters at DEPTH-1
//   shift_in  : value entering the tail on a shift
//   q         : entry 0 (head of the lane)
module fifo_lane
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [DEPTH-1:0][BITS-1:0] load_vec,
  input  logic                       shift,
  input  logic [BITS-1:0]            shift_in,
  output logic [BITS-1:0]            q
);

  logic [BITS-1:0] regs_q [DEPTH];

  // Load has priority over shift; the controller never asks for both, but the
  // ordering keeps a tile load authoritative if it ever did.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= load_vec[k];
    end else if (shift) begin
      for (int k = 0; k < DEPTH - 1; k++) regs_q[k] <= regs_q[k+1];
      regs_q[DEPTH-1] <= shift_in;
    end
  end

  assign q = regs_q[0];

endmodule

// File: rtl/skew_fifo_bank.sv
// LANES independent delay lanes feeding a systolic array edge. A tile is
// loaded in parallel (or pushed serially) while IDLE, then drained with a
// diagonal skew: lane i emits entry k on drain cycle i+k.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : tile present on load_data (IDLE only)
//   load_ready  : high in IDLE
//   load_data   : load_data[i][k] -> lane i entry k (k=0 emitted first)
//   push_en     : IDLE only, shift push_data[i] into the tail of lane i
//   push_data   : serial fill data, one word per lane
//   start       : begin the skewed drain
//   stall       : freeze the drain (takes effect at the next edge)
//   busy        : high while draining
//   done        : one-cycle pulse on the last non-stalled drain cycle
//   q, q_valid  : lane outputs; q[i]=FILL while lane i is outside its window
module skew_fifo_bank
  import fifo_pkg::*;
#(
  parameter int              LANES = 8,
  parameter int              DEPTH = 8,
  parameter int              BITS  = 64,
  parameter logic [BITS-1:0] FILL  = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  input  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] load_data,
  input  logic                                  push_en,
  input  logic [LANES-1:0][BITS-1:0]            push_data,
  input  logic                                  start,
  input  logic                                  stall,
  output logic                                  busy,
  output logic                                  done,
  output logic [LANES-1:0][BITS-1:0]            q,
  output logic [LANES-1:0]                      q_valid
);

  localparam int             CW   = cnt_w(DEPTH, LANES);
  localparam logic [CW-1:0]  LAST = CW'(DEPTH + LANES - 2);

  if (DEPTH < 2 || LANES < 1) begin : g_param_check
    $error("skew_fifo_bank: DEPTH>=2 and LANES>=1 required");
  end

  skew_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cnt_ext;
  logic          lane_load;
  logic          push;
  logic          drain_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done       = 1'b0;
    lane_load  = 1'b0;
    push       = 1'b0;
    drain_step = 1'b0;
    case (state_q)
      IDLE: begin
        // A load in the same cycle as start is captured and then drained.
        if (load_valid)   lane_load = 1'b1;
        else if (push_en) push      = 1'b1;
        if (start) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (!stall) begin
          drain_step = 1'b1;
          if (cnt_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == DRAIN);
  assign load_ready = (state_q == IDLE);
  assign cnt_ext    = 32'(cnt_q);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BITS-1:0] lane_q;
    logic            active;

    // Lane gi is inside its emission window for drain cycles gi..gi+DEPTH-1.
    assign active = busy && (cnt_ext >= 32'(gi)) && (cnt_ext < 32'(gi + DEPTH));

    fifo_lane #(
      .DEPTH (DEPTH),
      .BITS  (BITS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (lane_load),
      .load_vec (load_data[gi]),
      .shift    (push | (drain_step & active)),
      .shift_in (push ? push_data[gi] : '0),
      .q        (lane_q)
    );

    assign q[gi]       = active ? lane_q : FILL;
    assign q_valid[gi] = active;
  end

endmodule

// File: tb/tb_skew_fifo_bank.sv
module tb_skew_fifo_bank;

  localparam int              LANES = 4;
  localparam int              DEPTH = 4;
  localparam int              BITS  = 64;
  localparam logic [BITS-1:0] FILL  = 64'hF111_F111_F111_F111;
  localparam int              LAST  = DEPTH + LANES - 2;

  logic                                  clk = 1'b0;
  logic                                  rst = 1'b1;
  logic                                  load_valid = 1'b0;
  logic                                  load_ready;
  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] load_data = '0;
  logic                                  push_en = 1'b0;
  logic [LANES-1:0][BITS-1:0]            push_data = '0;
  logic                                  start = 1'b0;
  logic                                  stall = 1'b0;
  logic                                  busy;
  logic                                  done;
  logic [LANES-1:0][BITS-1:0]            q;
  logic [LANES-1:0]                      q_valid;

  typedef struct packed {
    logic [LANES-1:0]           vmask;
    logic [LANES-1:0][BITS-1:0] qv;
  } exp_t;

  exp_t                                  exp_q[$];
  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] mdl = '0;
  logic [LANES-1:0][BITS-1:0]            fill_vec;
  int                                    checks   = 0;
  int                                    failures = 0;

  always #5 clk = ~clk;

  skew_fifo_bank #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .BITS  (BITS),
    .FILL  (FILL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .push_en    (push_en),
    .push_data  (push_data),
    .start      (start),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .q          (q),
    .q_valid    (q_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Tile pattern d[i][k] = base + 16*i + k.
  task automatic make_tile(input int base);
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < DEPTH; k++)
        load_data[i][k] = BITS'(base + 16 * i + k);
  endtask

  // Scoreboard: one expected output frame per non-stalled drain cycle.
  // Lane i shows entry c-i while i <= c < i+DEPTH, FILL otherwise.
  task automatic push_expected();
    exp_t e;
    for (int c = 0; c <= LAST; c++) begin
      e = '0;
      for (int i = 0; i < LANES; i++) begin
        if (i <= c && c < i + DEPTH) begin
          e.vmask[i] = 1'b1;
          e.qv[i]    = mdl[i][c-i];
        end else begin
          e.qv[i] = FILL;
        end
      end
      exp_q.push_back(e);
    end
    mdl = '0;
  endtask

  task automatic model_push();
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH - 1; k++) mdl[i][k] = mdl[i][k+1];
      mdl[i][DEPTH-1] = push_data[i];
    end
  endtask

  // Runs the drain that was just started. Returns at wall cycle abort_at
  // (before comparing) if abort_at >= 0.
  task automatic run_drain(input string name, input int stall_lo, input int stall_hi,
                           input int abort_at, output int done_at);
    exp_t e;
    exp_t snap;
    int   c;
    logic prev_stall;
    logic exp_done;
    c          = 0;
    prev_stall = 1'b0;
    done_at    = -1;
    snap       = '0;
    for (int w = 0; w < 40; w++) begin
      if (w == abort_at) return;
      stall = (w >= stall_lo && w <= stall_hi);
      if (prev_stall) begin
        e = snap;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s underflow: cycle=%0d scoreboard empty, required frame", name, w);
          stall = 1'b0;
          return;
        end
        e = exp_q.pop_front();
      end
      exp_done = (c == LAST) && !stall;
      $display("%s cyc=%0d cnt=%0d stall=%b q_valid=%b done=%b q=%h",
               name, w, c, stall, q_valid, done, q);
      checks++;
      if (q_valid !== e.vmask) begin
        failures++;
        $display("FAIL %s q_valid: cycle=%0d got %b required %b", name, w, q_valid, e.vmask);
      end
      checks++;
      if (q !== e.qv) begin
        failures++;
        $display("FAIL %s q: cycle=%0d got %h required %h", name, w, q, e.qv);
      end
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL %s done: cycle=%0d got %b required %b", name, w, done, exp_done);
      end
      checks++;
      if (busy !== 1'b1 || load_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy/load_ready: cycle=%0d got %b/%b required 1/0",
                 name, w, busy, load_ready);
      end
      if (done === 1'b1) done_at = w;
      snap       = e;
      prev_stall = stall;
      if (!stall) c++;
      cyc();
      if (exp_done) break;
    end
    stall = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1 || q_valid !== '0 || q !== fill_vec) begin
      failures++;
      $display("FAIL %s end_idle: busy=%b load_ready=%b q_valid=%b required 0/1/0 with FILL",
               name, busy, load_ready, q_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s leftover: %0d frames unconsumed, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    push_expected();
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    $display("reset: q_valid=%b busy=%b load_ready=%b done=%b", q_valid, busy, load_ready, done);
    checks++;
    if (q !== fill_vec) begin
      failures++;
      $display("FAIL reset q: got %h required %h", q, fill_vec);
    end
    checks++;
    if (q_valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset flags: q_valid=%b busy=%b done=%b required 0/0/0", q_valid, busy, done);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset load_ready: got %b required 1", load_ready);
    end
  endtask

  task automatic test_basic_drain();
    int done_at;
    make_tile(0);
    load_valid = 1'b1;
    mdl        = load_data;
    cyc();
    load_valid = 1'b0;
    do_start();
    run_drain("basic", -1, -1, -1, done_at);
    checks++;
    if (done_at != 6) begin
      failures++;
      $display("FAIL basic done_cycle: got %0d required 6", done_at);
    end
  endtask

  task automatic test_stall();
    int done_at;
    make_tile(0);
    load_valid = 1'b1;
    mdl        = load_data;
    cyc();
    load_valid = 1'b0;
    do_start();
    run_drain("stall", 2, 3, -1, done_at);
    checks++;
    if (done_at != 8) begin
      failures++;
      $display("FAIL stall done_cycle: got %0d required 8", done_at);
    end
  endtask

  task automatic test_push();
    int done_at;
    for (int p = 1; p <= 4; p++) begin
      push_en = 1'b1;
      for (int i = 0; i < LANES; i++) push_data[i] = BITS'(p);
      model_push();
      cyc();
    end
    push_en = 1'b0;
    do_start();
    run_drain("push", -1, -1, -1, done_at);
    // Load and push together: only the loaded tile survives.
    make_tile(256);
    load_valid = 1'b1;
    push_en    = 1'b1;
    for (int i = 0; i < LANES; i++) push_data[i] = BITS'(99);
    mdl = load_data;
    cyc();
    load_valid = 1'b0;
    push_en    = 1'b0;
    do_start();
    run_drain("load_push", -1, -1, -1, done_at);
  endtask

  task automatic test_start_with_load();
    int done_at;
    make_tile(512);
    load_valid = 1'b1;
    mdl        = load_data;
    do_start();
    // Everything offered during DRAIN must be ignored.
    make_tile(768);
    load_valid = 1'b1;
    push_en    = 1'b1;
    for (int i = 0; i < LANES; i++) push_data[i] = BITS'(77);
    run_drain("start_load", -1, -1, -1, done_at);
    load_valid = 1'b0;
    push_en    = 1'b0;
    // Lanes drained empty and nothing was captured during DRAIN.
    do_start();
    run_drain("after_ignore", -1, -1, -1, done_at);
  endtask

  task automatic test_rst_mid_drain();
    int done_at;
    make_tile(1024);
    load_valid = 1'b1;
    mdl        = load_data;
    cyc();
    load_valid = 1'b0;
    do_start();
    run_drain("pre_rst", -1, -1, 3, done_at);
    rst = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid done_at_rst: got %b required 0", done);
    end
    cyc();
    rst = 1'b0;
    exp_q.delete();
    mdl = '0;
    $display("rst_mid: busy=%b q_valid=%b done=%b load_ready=%b", busy, q_valid, done, load_ready);
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid state: busy=%b load_ready=%b done=%b required 0/1/0",
               busy, load_ready, done);
    end
    checks++;
    if (q !== fill_vec || q_valid !== '0) begin
      failures++;
      $display("FAIL rst_mid outputs: q=%h q_valid=%b required FILL/0", q, q_valid);
    end
    do_start();
    run_drain("post_rst", -1, -1, -1, done_at);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) fill_vec[i] = FILL;
    test_reset();
    test_basic_drain();
    test_stall();
    test_push();
    test_start_with_load();
    test_rst_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
